// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits split into STAGES carry-chained
// slices, one slice resolved per register stage, with a freeze-the-whole-pipe handshake.
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int SW = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_param
    $error("pipelined_add_sub: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  // The pipe either advances as a whole or freezes as a whole.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits not yet consumed when this stage starts; the lowest SW of them are its slice.
    localparam int REM = WIDTH - k * SW;

    logic [REM-1:0]        a_src, b_src;
    logic                  c_src, v_src;
    logic [SW:0]           slice;
    logic [(k+1)*SW-1:0]   s_d, s_q;
    logic                  v_q, c_q;

    if (k == 0) begin : g_in
      assign a_src = in_a;
      assign b_src = in_sub ? ~in_b : in_b;
      assign c_src = in_sub | in_cin;
      assign v_src = in_valid;
      assign s_d   = slice[SW-1:0];
    end else begin : g_chain
      assign a_src = g_stage[k-1].g_pass.a_q;
      assign b_src = g_stage[k-1].g_pass.b_q;
      assign c_src = g_stage[k-1].c_q;
      assign v_src = g_stage[k-1].v_q;
      assign s_d   = {slice[SW-1:0], g_stage[k-1].s_q};
    end

    assign slice = {1'b0, a_src[SW-1:0]} + {1'b0, b_src[SW-1:0]} + {{SW{1'b0}}, c_src};

    // NOTE: registers are written with non-blocking assignments so every stage samples its
    // predecessor's pre-edge value; blocking here would let an operand race through the pipe.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_src;
        c_q <= slice[SW];
        s_q <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_pass
      logic [REM-SW-1:0] a_q, b_q;

      // NOTE: datapath registers are reset too, so out_sum and the flags read 0 out of reset
      // rather than X; validity itself is carried only by v_q.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_src[REM-1:SW];
          b_q <= b_src[REM-1:SW];
        end
      end
    end else begin : g_last
      logic ovf_q, zero_q;

      // Overflow: both addends share a sign that the result does not (b_src is already ~B for sub).
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= (a_src[SW-1] == b_src[SW-1]) && (slice[SW-1] != a_src[SW-1]);
          zero_q <= ~|s_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign out_sum   = g_stage[STAGES-1].s_q;
  assign out_cout  = g_stage[STAGES-1].c_q;
  assign out_ovf   = g_stage[STAGES-1].g_last.ovf_q;
  assign out_zero  = g_stage[STAGES-1].g_last.zero_q;

endmodule
